// File: rtl/display_pkg.sv
// display_pkg: segment patterns, FSM state type and sizing helpers for hex_display_driver
package display_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_HALT = 7'b0001001;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0011000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    // decimal digits needed for 2^w-1: floor(w*log10(2))+1
    function automatic int bcd_digits(int w);
        return w * 30103 / 100000 + 1;
    endfunction
    function automatic logic [63:0] pow10(int n);
        logic [63:0] p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: one BCD nibble to an active-low 7-segment pattern (g..a); blank forces all segments off
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);
    localparam logic [15:0][6:0] LUT = {{6{SEG_BLANK}}, SEG_DIGITS};
    assign seg = blank ? SEG_BLANK : LUT[nibble];
endmodule

// File: rtl/hex_display_driver.sv
// hex_display_driver: double-dabble binary-to-decimal converter driving DIGITS active-low 7-segment digits
// ports: clk/rst_n clock and async active-low reset; load_i+value_i start a conversion;
// halt_i overrides all digits with the halt glyph; busy_o/valid_o/ovf_o status; seg_o digit k at [7k+6:7k]
module hex_display_driver
    import display_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [DATA_W-1:0]   value_i,
    input  logic                halt_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic                ovf_o,
    output logic [7*DIGITS-1:0] seg_o
);
    // the BCD register must hold every digit of the input and every displayed digit
    localparam int NB = bcd_digits(DATA_W) > DIGITS ? bcd_digits(DATA_W) : DIGITS;
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam int CW = $clog2(DATA_W + 1);
    state_t state, state_nx;
    logic [DATA_W-1:0] bin;
    logic [4*NB-1:0] bcd, bcd_adj;
    logic [CW-1:0] cnt;
    logic ovf_pend, valid_r, ovf_r, load_ok, zero_above;
    logic [7*DIGITS-1:0] seg_r, seg_pat;
    logic [DIGITS-1:0] blank;
    assign load_ok = load_i && state != CONVERT;
    always_comb begin
        state_nx = state;
        state_nx = load_ok ? CONVERT : (state == CONVERT && cnt == '0) ? SHOW : state;
    end
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NB; k++)
            bcd_adj[4*k+:4] = bcd[4*k+:4] >= 4'd5 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
    end
    // a digit is blanked when it and every displayed digit above it are zero; digit 0 never is
    always_comb begin
        blank = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && bcd[4*k+:4] == 4'd0;
            blank[k] = BLANK_LZ != 0 && zero_above;
        end
    end
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        bcd_to_seg u_seg (
            .nibble(bcd[4*d+:4]),
            .blank (blank[d]),
            .seg   (seg_pat[7*d+:7])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
            ovf_pend <= 1'b0;
            seg_r <= {DIGITS{SEG_BLANK}};
            valid_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_ok) begin
                bin <= value_i;
                bcd <= '0;
                cnt <= CW'(DATA_W);
                ovf_pend <= 64'(value_i) > MAX_VAL;
            end else if (state == CONVERT) begin
                if (cnt != '0) begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt <= cnt - CW'(1);
                end else begin
                    seg_r <= ovf_pend ? {DIGITS{SEG_DASH}} : seg_pat;
                    valid_r <= 1'b1;
                    ovf_r <= ovf_pend;
                end
            end
        end
    end
    assign busy_o = state == CONVERT;
    assign valid_o = valid_r;
    assign ovf_o = ovf_r;
    assign seg_o = halt_i ? {DIGITS{SEG_HALT}} : seg_r;
endmodule

// File: tb/tb_hex_display_driver.sv
// tb_hex_display_driver: table, random and corner-case checks of three hex_display_driver configurations
module tb_hex_display_driver;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] HALT = 7'b0001001;
    logic clk = 1'b0, rst_n = 1'b0, load_i = 1'b0, halt_i = 1'b0;
    logic [15:0] value_i = '0;
    logic busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b, busy_c, valid_c, ovf_c;
    logic [34:0] seg_a, seg_b;
    logic [27:0] seg_c;
    logic [6:0] seg_tab [10];
    logic [69:0] prev_a;
    int tests = 0, fails = 0;
    typedef struct {
        logic [15:0] value;
        logic [34:0] exp_a;
        logic        exp_ovf_c;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    hex_display_driver #(.DATA_W(16), .DIGITS(5), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .value_i(value_i), .halt_i(halt_i),
        .busy_o(busy_a), .valid_o(valid_a), .ovf_o(ovf_a), .seg_o(seg_a));
    hex_display_driver #(.DATA_W(16), .DIGITS(5), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .value_i(value_i), .halt_i(halt_i),
        .busy_o(busy_b), .valid_o(valid_b), .ovf_o(ovf_b), .seg_o(seg_b));
    hex_display_driver #(.DATA_W(16), .DIGITS(4), .BLANK_LZ(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .value_i(value_i), .halt_i(halt_i),
        .busy_o(busy_c), .valid_o(valid_c), .ovf_o(ovf_c), .seg_o(seg_c));

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // decimal digits by division, dash on overflow, leading zeros above the top digit blanked
    function automatic logic [69:0] model(longint unsigned v, int digits, bit blz);
        longint unsigned lim = 1, q = v;
        logic [69:0] r = '0;
        for (int k = 0; k < digits; k++) lim *= 10;
        for (int k = 0; k < digits; k++) begin
            r[7*k+:7] = v >= lim ? DASH : (blz && k > 0 && q == 0) ? BL : seg_tab[q % 10];
            q /= 10;
        end
        return r;
    endfunction

    task automatic check_all(input string tag, input longint unsigned v);
        chk({tag, " seg_a"}, seg_a, model(v, 5, 1));
        chk({tag, " seg_b"}, seg_b, model(v, 5, 0));
        chk({tag, " seg_c"}, seg_c, model(v, 4, 1));
        chk({tag, " ovf_c"}, ovf_c, v > 9999);
        chk({tag, " ovf_a"}, ovf_a, v > 99999);
        chk({tag, " valid"}, {valid_a, valid_b, valid_c}, 3'b111);
        chk({tag, " busy"}, {busy_a, busy_b, busy_c}, 3'b000);
    endtask

    task automatic load(input logic [15:0] v);
        @(negedge clk);
        value_i = v;
        load_i = 1'b1;
        @(posedge clk);
        #1;
        load_i = 1'b0;
    endtask

    // load, confirm old content holds through edge 16, new content lands on edge 17
    task automatic run_conv(input string tag, input logic [15:0] v);
        load(v);
        chk({tag, " busy@1"}, busy_a, 1);
        repeat (16) @(posedge clk);
        #1;
        chk({tag, " busy@16"}, busy_a, 1);
        chk({tag, " hold@16"}, seg_a, prev_a);
        @(posedge clk);
        #1;
        check_all(tag, v);
        prev_a = model(v, 5, 1);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
        vecs[0] = '{16'd1234, {BL, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0};
        vecs[1] = '{16'd0, {BL, BL, BL, BL, 7'b1000000}, 1'b0};
        vecs[2] = '{16'd12345, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}, 1'b1};
        vecs[3] = '{16'd99, {BL, BL, BL, 7'b0011000, 7'b0011000}, 1'b0};
        vecs[4] = '{16'd65535, {7'b0000010, 7'b0010010, 7'b0010010, 7'b0110000, 7'b0010010}, 1'b1};
        vecs[5] = '{16'd9999, {BL, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000}, 1'b0};
        prev_a = {35'b0, {5{BL}}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset seg_a", seg_a, {5{BL}});
        chk("reset seg_c", seg_c, {4{BL}});
        chk("reset flags", {busy_a, valid_a, ovf_a, busy_c, valid_c, ovf_c}, 6'b0);
        @(negedge clk);
        halt_i = 1'b1;
        #1;
        chk("halt idle seg_a", seg_a, {5{HALT}});
        @(negedge clk);
        halt_i = 1'b0;
        #1;
        chk("unhalt idle blank", seg_a, {5{BL}});

        for (int i = 0; i < 6; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].value);
            chk($sformatf("vec%0d table seg_a", i), seg_a, vecs[i].exp_a);
            chk($sformatf("vec%0d table ovf_c", i), ovf_c, vecs[i].exp_ovf_c);
        end

        for (int i = 0; i < 20; i++) begin
            logic [15:0] v;
            v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(0, 65535));
            run_conv($sformatf("rnd%0d", i), v);
        end

        load(16'd500);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            load_i = (c == 5);
            value_i = (c == 5) ? 16'd7 : 16'd500;
            @(posedge clk);
        end
        #1;
        check_all("ignore", 500);
        repeat (3) @(posedge clk);
        #1;
        chk("ignore no reconv busy", busy_a, 0);
        chk("ignore still 500", seg_a, model(500, 5, 1));
        prev_a = model(500, 5, 1);

        load(16'd4321);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", {busy_a, busy_b, busy_c}, 3'b0);
        chk("midreset valid", {valid_a, valid_b, valid_c}, 3'b0);
        chk("midreset seg_a", seg_a, {5{BL}});
        chk("midreset seg_c", seg_c, {4{BL}});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postreset seg_a", seg_a, {5{BL}});
        chk("postreset busy", busy_a, 0);
        prev_a = {35'b0, {5{BL}}};
        run_conv("first after reset", 16'd42);

        @(negedge clk);
        halt_i = 1'b1;
        #1;
        chk("halt show seg_a", seg_a, {5{HALT}});
        chk("halt show seg_c", seg_c, {4{HALT}});
        @(negedge clk);
        halt_i = 1'b0;
        #1;
        chk("unhalt restore", seg_a, model(42, 5, 1));
        @(negedge clk);
        halt_i = 1'b1;
        load(16'd777);
        chk("halt conv busy", busy_a, 1);
        repeat (17) @(posedge clk);
        #1;
        chk("halt conv seg_a", seg_a, {5{HALT}});
        chk("halt conv done", {busy_a, valid_a}, 2'b01);
        @(negedge clk);
        halt_i = 1'b0;
        #1;
        check_all("after halt conv", 777);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
